serial_pattern_detector: RTL and testbench
==========================================

Name: serial_pattern_detector

Overview:
Serial-stream consumer that sits directly downstream of the single-bit D flip-flop stage. It takes the registered bit (the flip-flop's Q) plus a qualifying valid, shifts accepted bits into a WIDTH-bit window, and compares the window against a fixed PATTERN. On each hit it emits a one-cycle match pulse and updates a saturating hit counter. A fill guard blocks matches until WIDTH real bits have arrived since reset or clear.

Parameters:
WIDTH, 4, pattern/window length in bits (>=2)
PATTERN, 4'b1011, target sequence; MSB = oldest bit, LSB = newest bit
CNT_W, 8, width of match counter

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
din  input  1  serial data bit, driven by the upstream flip-flop Q
din_valid  input  1  din accepted on a rising clk edge only when 1
clr  input  1  synchronous clear, active-high
match  output  1  registered one-cycle pulse per detected pattern
match_count  output  CNT_W  saturating count of matches
window  output  WIDTH  current shift window, newest bit in LSB
filled  output  1  1 once WIDTH bits have been accepted (state RUN)

Behaviour:
- Reset (rst=0, asynchronous, takes effect without clk): window=0, match=0, match_count=0, fill counter=0, state=FILL, filled=0. Outputs hold these values while rst=0. Release is sampled on the next rising edge.
- Each edge: priority is rst > clr > din_valid.
- clr=1 at an edge: same values as reset, regardless of din_valid. The bit presented in that cycle is discarded.
- din_valid=1 at an edge (clr=0): window <= {window[WIDTH-2:0], din}.
- din_valid=0 at an edge: window, state, fill counter and match_count hold. match <= 0.
- State FILL: fill counter counts accepted bits, 0..WIDTH-1. The accepted bit that brings the total to WIDTH moves the state to RUN.
- State RUN: the fill counter is frozen. The state stays RUN until reset or clr.
- Match condition on an accepting edge: the shifted window equals PATTERN, and either the state is RUN or this bit is the WIDTH-th bit.
- When the match condition holds:
  - match <= 1 for exactly the following cycle (latency 1 clk from the accepting edge).
  - match_count <= match_count+1, saturating at 2^CNT_W-1.
- Otherwise match <= 0.
- Overlapping matches are allowed. There is no window flush after a hit.
- Back-to-back matches on consecutive valid edges produce match high on consecutive cycles (possible only for self-overlapping patterns such as all-ones).
- filled = (state==RUN). It is registered and rises in the cycle after the WIDTH-th accepted bit, the same cycle as any match from that bit.
- window, match_count and filled change only on clock edges (or on async reset), never combinationally from din.
- Fill-guard example: PATTERN=4'b0011 after reset with only three bits 0,1,1 accepted gives window=0011. match must stay 0 because only 3 bits have been accepted.

Test Plan:
1. Reset, then din 1,0,1,1 with din_valid=1 on 4 consecutive edges -> window=1011, filled=1 and match=1 in the cycle after the 4th edge; match=0 in the next cycle; match_count=1.
2. Stream 1,0,1,1,0,1,1 continuous valid -> match pulses after bit 4 and bit 7 (overlap); match_count=2; no other pulses.
3. Stream 1,0,1,1 with din_valid=0 for 3 cycles between bits 2 and 3, din toggling during those gaps -> single match after the 4th accepted bit; window unaffected by non-valid cycles.
4. PATTERN=4'b0011: reset, accept 0,1,1 -> window=0011, filled=0, match=0; accept 1 -> window=0111, filled=1, match=0; then accept 0,0,1,1 -> match=1 after the final 1, match_count=1.
5. CNT_W=2, feed 1011 repeated 5 times -> 5 match pulses; match_count sequence 1,2,3,3,3 (saturates).
6. Mid-stream after accepting 1,0,1: case (a) assert clr with din_valid=1, din=1; case (b) pull rst low between clock edges.
   - Both cases: all outputs 0 immediately (reset) or at the edge (clr), state FILL.
   - Following 1,0,1,1 -> exactly one match; the pre-clear/pre-reset bits never contribute.

Source files
------------

// File: rtl/serial_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_detector
// Purpose  : Shifts qualified serial bits into a WIDTH-bit window and flags
//            every occurrence of PATTERN with a one-cycle registered pulse.
//            Each hit also bumps a saturating hit counter. A fill guard
//            suppresses hits until WIDTH real bits have been accepted since
//            reset or clear.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous reset, active low
//   din          in   1      serial data bit (upstream flop Q)
//   din_valid    in   1      din is accepted on an edge only when high
//   clr          in   1      synchronous clear, active high
//   match        out  1      one-cycle pulse per detected pattern
//   match_count  out  CNT_W  saturating count of matches
//   window       out  WIDTH  shift window, newest bit in the LSB
//   filled       out  1      high once WIDTH bits have been accepted
// ============================================================================
module serial_pattern_detector #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [WIDTH-1:0] window,
  output logic             filled
);

  // Fill counter only needs to reach WIDTH-1; the WIDTH-th bit moves the
  // state to RUN instead of incrementing.
  localparam int FC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [FC_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [WIDTH-1:0]  window_q, window_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  match_count_q, match_count_d;

  logic [WIDTH-1:0]  shifted;
  logic              last_fill_bit;
  logic              guard_open;

  assign shifted       = {window_q[WIDTH-2:0], din};
  assign last_fill_bit = (state_q == ST_FILL) && (fill_cnt_q == FC_W'(WIDTH - 1));
  // A hit is allowed once running, or on the very bit that completes the fill.
  assign guard_open    = (state_q == ST_RUN) || last_fill_bit;

  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    window_d      = window_q;
    match_d       = 1'b0;
    match_count_d = match_count_q;

    if (clr) begin
      state_d       = ST_FILL;
      fill_cnt_d    = '0;
      window_d      = '0;
      match_count_d = '0;
    end else if (din_valid) begin
      window_d = shifted;

      if (state_q == ST_FILL) begin
        if (last_fill_bit) begin
          state_d = ST_RUN;
        end else begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end

      if ((shifted == PATTERN) && guard_open) begin
        match_d = 1'b1;
        if (match_count_q != {CNT_W{1'b1}}) begin
          match_count_d = match_count_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_FILL;
      fill_cnt_q    <= '0;
      window_q      <= '0;
      match_q       <= 1'b0;
      match_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      window_q      <= window_d;
      match_q       <= match_d;
      match_count_q <= match_count_d;
    end
  end

  assign match       = match_q;
  assign match_count = match_count_q;
  assign window      = window_q;
  assign filled      = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pattern_detector
// Purpose  : Self-checking bench for serial_pattern_detector. Three instances
//            share one stimulus stream: default (1011, 8-bit count), pattern
//            0011, and pattern 1011 with a 2-bit saturating count. A
//            reference model keeps the history of accepted bits and decides
//            hits from that history.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_detector;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic clr = 1'b0;

  logic       match0, match1, match2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [3:0] win0, win1, win2;
  logic       filled0, filled1, filled2;

  always #5 clk = ~clk;

  serial_pattern_detector #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
    .match(match0), .match_count(cnt0), .window(win0), .filled(filled0));

  serial_pattern_detector #(.WIDTH(4), .PATTERN(4'b0011), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
    .match(match1), .match_count(cnt1), .window(win1), .filled(filled1));

  serial_pattern_detector #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
    .match(match2), .match_count(cnt2), .window(win2), .filled(filled2));

  // ---------------- reference model ----------------
  logic [3:0] pats [NI] = '{4'b1011, 4'b0011, 4'b1011};
  int         cmax [NI] = '{255, 255, 3};
  bit         hist [$];          // last accepted bits, oldest first
  int         n_acc;             // accepted bits since reset/clear
  bit         exp_match [NI];
  int         exp_cnt [NI];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_window();
    logic [3:0] w = 4'b0000;
    foreach (hist[k]) w = {w[2:0], hist[k]};
    return w;
  endfunction

  task automatic model_clear();
    hist.delete();
    n_acc = 0;
    for (int i = 0; i < NI; i++) begin
      exp_match[i] = 1'b0;
      exp_cnt[i]   = 0;
    end
  endtask

  task automatic model_edge(input bit d, input bit v, input bit c);
    if (c) begin
      model_clear();
    end else if (v) begin
      hist.push_back(d);
      if (hist.size() > 4) void'(hist.pop_front());
      if (n_acc < 1000) n_acc++;
      for (int i = 0; i < NI; i++) begin
        exp_match[i] = (n_acc >= 4) && (model_window() == pats[i]);
        if (exp_match[i] && exp_cnt[i] < cmax[i]) exp_cnt[i]++;
      end
    end else begin
      for (int i = 0; i < NI; i++) exp_match[i] = 1'b0;
    end
  endtask

  task automatic check_all();
    logic [3:0] w;
    logic       f;
    w = model_window();
    f = (n_acc >= 4);
    check_eq("match0",  32'(match0),  32'(exp_match[0]));
    check_eq("match1",  32'(match1),  32'(exp_match[1]));
    check_eq("match2",  32'(match2),  32'(exp_match[2]));
    check_eq("count0",  32'(cnt0),    32'(exp_cnt[0]));
    check_eq("count1",  32'(cnt1),    32'(exp_cnt[1]));
    check_eq("count2",  32'(cnt2),    32'(exp_cnt[2]));
    check_eq("window0", 32'(win0),    32'(w));
    check_eq("window1", 32'(win1),    32'(w));
    check_eq("window2", 32'(win2),    32'(w));
    check_eq("filled0", 32'(filled0), 32'(f));
    check_eq("filled1", 32'(filled1), 32'(f));
    check_eq("filled2", 32'(filled2), 32'(f));
  endtask

  // One clock: drive inputs, take the edge, update model, check 1 ns later.
  task automatic cycle(input bit d, input bit v, input bit c);
    din = d; din_valid = v; clr = c;
    @(posedge clk);
    model_edge(d, v, c);
    #1;
    check_all();
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) cycle(bits[k], 1'b1, 1'b0);
  endtask

  // Reset pulse placed between clock edges; outputs must clear without clk.
  task automatic async_reset();
    #1;
    rst = 1'b0;
    model_clear();
    #1;
    check_all();
    #1;
    rst = 1'b1;
  endtask

  initial begin
    model_clear();
    #1 rst = 1'b0;
    #2;
    check_all();                      // reset values before any edge
    @(posedge clk);
    #1;
    check_all();                      // still held in reset
    rst = 1'b1;

    // 1: single 1011 straight after reset
    feed(32'b1011, 4);
    cycle(1'b0, 1'b0, 1'b0);          // match drops on idle cycle
    // 2: overlapping hits
    cycle(1'b0, 1'b0, 1'b1);
    feed(32'b1011011, 7);
    // 3: gaps with toggling din between bits 2 and 3
    cycle(1'b0, 1'b0, 1'b1);
    feed(32'b10, 2);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    feed(32'b11, 2);
    // 4: fill guard for pattern 0011
    cycle(1'b0, 1'b0, 1'b1);
    feed(32'b011, 3);
    feed(32'b1, 1);
    feed(32'b0011, 4);
    // 5: saturation on the 2-bit counter
    cycle(1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 5; r++) feed(32'b1011, 4);
    // 6a: clear with valid data discards the presented bit
    cycle(1'b0, 1'b0, 1'b1);
    feed(32'b101, 3);
    cycle(1'b1, 1'b1, 1'b1);
    feed(32'b1011, 4);
    // 6b: asynchronous reset mid-stream
    feed(32'b101, 3);
    async_reset();
    feed(32'b1011, 4);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 5) begin
        async_reset();
        @(negedge clk);
      end else begin
        cycle(1'($urandom), ($urandom_range(0, 9) < 7), (r < 25));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
